ama_riscv_ctrl_unit: RTL and testbench
======================================

Name: ama_riscv_ctrl_unit

Overview:
- Parametrised successor to the single-type ID-stage decoder.
- Decodes all RV32I base opcodes (R, I, load, store, branch, JALR, JAL, LUI, AUIPC) into registered datapath controls.
- Owns the front-end control FSM: post-reset start-address hold, branch-resolve stall, jump fetch flush and illegal-opcode flagging.
- Sits in ID; all outputs drive the next pipeline edge.

Parameters:
RST_HOLD, 2, cycles pc_sel=START is held after rst deasserts (1..15).
BR_RES_LAT, 1, cycles from branch decode until bc_a_eq_b/bc_a_lt_b are valid (1..7).
ILLEGAL_BUBBLE, 1, when 1 an illegal opcode also asserts clear_id for one cycle.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  synchronous, active-high reset.
inst_id  in  32  instruction in ID.
inst_valid  in  1  inst_id qualifies; 0 means bubble, decodes as NOP.
bc_a_eq_b  in  1  branch compare equal.
bc_a_lt_b  in  1  branch compare less-than (signedness per bc_uns).
stall_if  out  1  hold IF stage.
clear_if  out  1  flush IF stage.
clear_id  out  1  flush ID stage.
pc_sel  out  2  0=INC4, 1=ALU, 2=BP, 3=START.
pc_we  out  1  PC write enable.
imem_en  out  1  instruction memory enable.
branch_inst  out  1  branch in EX.
store_inst  out  1  store in EX.
alu_op_sel  out  4  {funct7[5],funct3}; 0000=add.
alu_a_sel  out  1  0=RS1, 1=PC.
alu_b_sel  out  1  0=RS2, 1=IMM.
ig_sel  out  3  0=off, 1=I, 2=S, 3=B, 4=J, 5=U.
bc_uns  out  1  unsigned compare (funct3[1]).
dmem_en  out  1  data memory enable.
load_sm_en  out  1  load sign/mask enable.
wb_sel  out  2  0=DMEM, 1=ALU, 2=INC4.
reg_we  out  1  register file write enable.
illegal_inst  out  1  one-cycle pulse on unsupported opc5 or inst_id[1:0]!=2'b11.

Behaviour:
- rst: synchronous, active-high; clock clk. rst dominates every state, mid-operation included.
- Reset values: pc_sel=3, pc_we=1, imem_en=1, stall_if=1, clear_if=1, clear_id=1; all other outputs 0 (alu_op_sel=0000, wb_sel=0, ig_sel=0). FSM=S_RST, counter=RST_HOLD-1.
- All outputs are registered: decode of inst_id appears one cycle later.
- States:
  - S_RST: outputs hold reset values until counter reaches 0, then -> S_RUN. Inputs are ignored.
  - S_RUN: decode every valid inst.
  - S_BR: branch wait; counter loads BR_RES_LAT-1. While in S_BR: stall_if=1, pc_we=0, clear_id=1, reg_we=0, dmem_en=0. On counter==0, evaluate taken:
    - funct3 000 eq; 001 !eq; 100/110 lt; 101/111 !lt.
    - Taken: pc_sel=1, pc_we=1, clear_if=1 for one cycle. Not taken: pc_sel=0, pc_we=1.
    - Then -> S_RUN.
  - S_JMP: one cycle with clear_if=1, clear_id=1, then -> S_RUN.
- Decode per opc5 (pc_sel=0, pc_we=1, imem_en=1 unless noted):
  - R: alu_b=RS2, ig=0, wb=ALU, reg_we=1.
  - I-arith: alu_b=IMM, ig=I, wb=ALU, reg_we=1. alu_op={funct3==101?funct7[5]:0, funct3}.
  - LOAD: add, IMM, ig=I, dmem_en=1, load_sm_en=1, wb=DMEM, reg_we=1.
  - STORE: add, IMM, ig=S, dmem_en=1, store_inst=1, reg_we=0.
  - BRANCH: a=PC, b=IMM, ig=B, branch_inst=1, bc_uns=funct3[1], reg_we=0 -> S_BR.
  - JAL: a=PC, b=IMM, ig=J, pc_sel=1, wb=INC4, reg_we=1 -> S_JMP.
  - JALR: a=RS1, b=IMM, ig=I, pc_sel=1, wb=INC4, reg_we=1 -> S_JMP.
  - LUI: ig=U, b=IMM, alu_op=1111 (pass B), wb=ALU, reg_we=1.
  - AUIPC: a=PC, b=IMM, ig=U, add, wb=ALU, reg_we=1.
  - Other (or inst_id[1:0]!=2'b11): illegal_inst=1 for one cycle. reg_we, dmem_en, store_inst and branch_inst are forced 0; PC continues INC4. clear_id=ILLEGAL_BUBBLE.
- inst_valid=0 in S_RUN: NOP. reg_we, dmem_en, store_inst and branch_inst are 0; pc_we=1, pc_sel=0.
- Instructions arriving in S_BR/S_JMP are ignored; they are flushed.
- Branch followed by jump: the jump decodes only after returning to S_RUN.

Test Plan:
- rst high 3 cycles, release with RST_HOLD=2 -> pc_sel=3, pc_we=1 for 2 more cycles, then first ADD (0x002081B3) gives alu_op=0000, wb=1, reg_we=1.
- SUB 0x40208133 -> alu_op=1000, alu_b_sel=0, reg_we=1; SRAI 0x4030D093 -> alu_op=1101, alu_b_sel=1, ig=1.
- BEQ 0x00208463 with bc_a_eq_b=1, BR_RES_LAT=2 -> stall_if=1 for 2 cycles, then pc_sel=1, clear_if=1; repeat with eq=0 -> pc_sel=0, no clear_if.
- JAL 0x008000EF -> pc_sel=1, wb=2, reg_we=1, ig=4, next cycle clear_if=clear_id=1; next inst decodes normally after.
- Opcode 0x0000007F -> illegal_inst single-cycle pulse, reg_we=0, dmem_en=0, pc_sel=0.
- rst asserted during S_BR -> next cycle pc_sel=3, stall_if=1, branch_inst=0, FSM restarts RST_HOLD count.

Source files
------------

// File: rtl/ama_riscv_ctrl_unit.sv
// ama_riscv_ctrl_unit
// ID-stage control unit: decodes the RV32I base opcodes into registered
// datapath controls and runs the front-end control FSM (start-address hold
// after reset, branch-resolve stall, jump fetch flush, illegal-opcode flag).
// Every output is registered, so the decode of inst_id shows up one cycle later.

module ama_riscv_ctrl_unit #(
    parameter int RST_HOLD       = 2,  // cycles pc_sel=START is held after rst (1..15)
    parameter int BR_RES_LAT     = 1,  // cycles until branch compare is valid (1..7)
    parameter int ILLEGAL_BUBBLE = 1   // illegal opcode also flushes ID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_id,
    input  logic        inst_valid,
    input  logic        bc_a_eq_b,
    input  logic        bc_a_lt_b,
    output logic        stall_if,
    output logic        clear_if,
    output logic        clear_id,
    output logic [1:0]  pc_sel,
    output logic        pc_we,
    output logic        imem_en,
    output logic        branch_inst,
    output logic        store_inst,
    output logic [3:0]  alu_op_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [2:0]  ig_sel,
    output logic        bc_uns,
    output logic        dmem_en,
    output logic        load_sm_en,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic        illegal_inst
);

    // opcode[6:2] values of the supported RV32I groups
    localparam logic [4:0] OPC5_R      = 5'b01100;
    localparam logic [4:0] OPC5_I      = 5'b00100;
    localparam logic [4:0] OPC5_LOAD   = 5'b00000;
    localparam logic [4:0] OPC5_STORE  = 5'b01000;
    localparam logic [4:0] OPC5_BRANCH = 5'b11000;
    localparam logic [4:0] OPC5_JALR   = 5'b11001;
    localparam logic [4:0] OPC5_JAL    = 5'b11011;
    localparam logic [4:0] OPC5_LUI    = 5'b01101;
    localparam logic [4:0] OPC5_AUIPC  = 5'b00101;

    // pc_sel encodings
    localparam logic [1:0] PC_INC4  = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_START = 2'd3;

    // immediate generator selections
    localparam logic [2:0] IG_OFF = 3'd0;
    localparam logic [2:0] IG_I   = 3'd1;
    localparam logic [2:0] IG_S   = 3'd2;
    localparam logic [2:0] IG_B   = 3'd3;
    localparam logic [2:0] IG_J   = 3'd4;
    localparam logic [2:0] IG_U   = 3'd5;

    // write-back selections
    localparam logic [1:0] WB_DMEM = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_INC4 = 2'd2;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [3:0] RST_CNT = 4'(RST_HOLD - 1);
    localparam logic [3:0] BR_CNT  = 4'(BR_RES_LAT - 1);
    localparam logic       ILL_CLR = (ILLEGAL_BUBBLE != 0);

    typedef enum logic [1:0] {
        S_RST = 2'd0,
        S_RUN = 2'd1,
        S_BR  = 2'd2,
        S_JMP = 2'd3
    } state_t;

    // all registered controls, in output-port order
    typedef struct packed {
        logic       stall_if;
        logic       clear_if;
        logic       clear_id;
        logic [1:0] pc_sel;
        logic       pc_we;
        logic       imem_en;
        logic       branch_inst;
        logic       store_inst;
        logic [3:0] alu_op_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] ig_sel;
        logic       bc_uns;
        logic       dmem_en;
        logic       load_sm_en;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       illegal_inst;
    } ctrl_t;

    // values driven while reset or the start-address hold is active
    localparam ctrl_t CTRL_RST = '{
        stall_if: 1'b1, clear_if: 1'b1, clear_id: 1'b1, pc_sel: PC_START,
        pc_we: 1'b1, imem_en: 1'b1, branch_inst: 1'b0, store_inst: 1'b0,
        alu_op_sel: ALU_ADD, alu_a_sel: 1'b0, alu_b_sel: 1'b0, ig_sel: IG_OFF,
        bc_uns: 1'b0, dmem_en: 1'b0, load_sm_en: 1'b0, wb_sel: WB_DMEM,
        reg_we: 1'b0, illegal_inst: 1'b0
    };

    // bubble: fetch keeps advancing by 4, nothing architectural is written
    localparam ctrl_t CTRL_NOP = '{
        stall_if: 1'b0, clear_if: 1'b0, clear_id: 1'b0, pc_sel: PC_INC4,
        pc_we: 1'b1, imem_en: 1'b1, branch_inst: 1'b0, store_inst: 1'b0,
        alu_op_sel: ALU_ADD, alu_a_sel: 1'b0, alu_b_sel: 1'b0, ig_sel: IG_OFF,
        bc_uns: 1'b0, dmem_en: 1'b0, load_sm_en: 1'b0, wb_sel: WB_DMEM,
        reg_we: 1'b0, illegal_inst: 1'b0
    };

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [2:0] br_f3_reg, br_f3_next;
    ctrl_t      ctrl_reg, ctrl_next;

    // instruction fields
    logic [4:0] opc5;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_inst;

    assign opc5        = inst_id[6:2];
    assign funct3      = inst_id[14:12];
    assign funct7_5    = inst_id[30];
    assign unused_inst = ^{inst_id[31], inst_id[29:15], inst_id[11:7]};

    // combinational decode of the instruction currently in ID
    ctrl_t dec_ctrl;
    logic  dec_branch;
    logic  dec_jump;
    logic  br_taken;

    // opcode decode; anything unrecognised becomes an illegal-instruction bubble
    always_comb begin
        dec_ctrl   = CTRL_NOP;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        if (inst_id[1:0] != 2'b11) begin
            dec_ctrl.illegal_inst = 1'b1;
            dec_ctrl.clear_id     = ILL_CLR;
        end else begin
            case (opc5)
                OPC5_R: begin
                    dec_ctrl.alu_op_sel = {funct7_5, funct3};
                    dec_ctrl.wb_sel     = WB_ALU;
                    dec_ctrl.reg_we     = 1'b1;
                end
                OPC5_I: begin
                    // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate data
                    dec_ctrl.alu_op_sel = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                    dec_ctrl.alu_b_sel  = 1'b1;
                    dec_ctrl.ig_sel     = IG_I;
                    dec_ctrl.wb_sel     = WB_ALU;
                    dec_ctrl.reg_we     = 1'b1;
                end
                OPC5_LOAD: begin
                    dec_ctrl.alu_b_sel  = 1'b1;
                    dec_ctrl.ig_sel     = IG_I;
                    dec_ctrl.dmem_en    = 1'b1;
                    dec_ctrl.load_sm_en = 1'b1;
                    dec_ctrl.wb_sel     = WB_DMEM;
                    dec_ctrl.reg_we     = 1'b1;
                end
                OPC5_STORE: begin
                    dec_ctrl.alu_b_sel  = 1'b1;
                    dec_ctrl.ig_sel     = IG_S;
                    dec_ctrl.dmem_en    = 1'b1;
                    dec_ctrl.store_inst = 1'b1;
                end
                OPC5_BRANCH: begin
                    dec_ctrl.alu_a_sel   = 1'b1;
                    dec_ctrl.alu_b_sel   = 1'b1;
                    dec_ctrl.ig_sel      = IG_B;
                    dec_ctrl.branch_inst = 1'b1;
                    dec_ctrl.bc_uns      = funct3[1];
                    dec_branch           = 1'b1;
                end
                OPC5_JAL: begin
                    dec_ctrl.alu_a_sel = 1'b1;
                    dec_ctrl.alu_b_sel = 1'b1;
                    dec_ctrl.ig_sel    = IG_J;
                    dec_ctrl.pc_sel    = PC_ALU;
                    dec_ctrl.wb_sel    = WB_INC4;
                    dec_ctrl.reg_we    = 1'b1;
                    dec_jump           = 1'b1;
                end
                OPC5_JALR: begin
                    dec_ctrl.alu_b_sel = 1'b1;
                    dec_ctrl.ig_sel    = IG_I;
                    dec_ctrl.pc_sel    = PC_ALU;
                    dec_ctrl.wb_sel    = WB_INC4;
                    dec_ctrl.reg_we    = 1'b1;
                    dec_jump           = 1'b1;
                end
                OPC5_LUI: begin
                    dec_ctrl.alu_op_sel = ALU_PASSB;
                    dec_ctrl.alu_b_sel  = 1'b1;
                    dec_ctrl.ig_sel     = IG_U;
                    dec_ctrl.wb_sel     = WB_ALU;
                    dec_ctrl.reg_we     = 1'b1;
                end
                OPC5_AUIPC: begin
                    dec_ctrl.alu_a_sel = 1'b1;
                    dec_ctrl.alu_b_sel = 1'b1;
                    dec_ctrl.ig_sel    = IG_U;
                    dec_ctrl.wb_sel    = WB_ALU;
                    dec_ctrl.reg_we    = 1'b1;
                end
                default: begin
                    dec_ctrl.illegal_inst = 1'b1;
                    dec_ctrl.clear_id     = ILL_CLR;
                end
            endcase
        end
    end

    // branch outcome from the stored funct3 and the comparator flags
    always_comb begin
        case (br_f3_reg)
            3'b000:          br_taken = bc_a_eq_b;
            3'b001:          br_taken = !bc_a_eq_b;
            3'b100, 3'b110:  br_taken = bc_a_lt_b;
            3'b101, 3'b111:  br_taken = !bc_a_lt_b;
            default:         br_taken = 1'b0;
        endcase
    end

    // next-state and next-control selection for the front-end FSM
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        br_f3_next = br_f3_reg;
        ctrl_next  = CTRL_RST;
        case (state_reg)
            S_RST: begin
                ctrl_next = CTRL_RST;
                if (cnt_reg == 4'd0) begin
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RUN: begin
                ctrl_next = CTRL_NOP;
                if (inst_valid) begin
                    ctrl_next = dec_ctrl;
                    if (dec_branch) begin
                        state_next = S_BR;
                        cnt_next   = BR_CNT;
                        br_f3_next = funct3;
                    end else if (dec_jump) begin
                        state_next = S_JMP;
                    end
                end
            end
            S_BR: begin
                // hold fetch and squash ID until the comparator result is valid
                ctrl_next          = CTRL_NOP;
                ctrl_next.stall_if = 1'b1;
                ctrl_next.clear_id = 1'b1;
                ctrl_next.pc_we    = 1'b0;
                ctrl_next.bc_uns   = br_f3_reg[1];
                if (cnt_reg == 4'd0) begin
                    ctrl_next.pc_we    = 1'b1;
                    ctrl_next.pc_sel   = br_taken ? PC_ALU : PC_INC4;
                    ctrl_next.clear_if = br_taken;
                    state_next         = S_RUN;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_JMP: begin
                // drop the wrong-path instructions fetched behind the jump
                ctrl_next          = CTRL_NOP;
                ctrl_next.clear_if = 1'b1;
                ctrl_next.clear_id = 1'b1;
                state_next         = S_RUN;
            end
            default: begin
                state_next = S_RST;
                cnt_next   = RST_CNT;
            end
        endcase
    end

    // state, counter and registered controls; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RST;
            cnt_reg   <= RST_CNT;
            br_f3_reg <= 3'b000;
            ctrl_reg  <= CTRL_RST;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            br_f3_reg <= br_f3_next;
            ctrl_reg  <= ctrl_next;
        end
    end

    assign stall_if     = ctrl_reg.stall_if;
    assign clear_if     = ctrl_reg.clear_if;
    assign clear_id     = ctrl_reg.clear_id;
    assign pc_sel       = ctrl_reg.pc_sel;
    assign pc_we        = ctrl_reg.pc_we;
    assign imem_en      = ctrl_reg.imem_en;
    assign branch_inst  = ctrl_reg.branch_inst;
    assign store_inst   = ctrl_reg.store_inst;
    assign alu_op_sel   = ctrl_reg.alu_op_sel;
    assign alu_a_sel    = ctrl_reg.alu_a_sel;
    assign alu_b_sel    = ctrl_reg.alu_b_sel;
    assign ig_sel       = ctrl_reg.ig_sel;
    assign bc_uns       = ctrl_reg.bc_uns;
    assign dmem_en      = ctrl_reg.dmem_en;
    assign load_sm_en   = ctrl_reg.load_sm_en;
    assign wb_sel       = ctrl_reg.wb_sel;
    assign reg_we       = ctrl_reg.reg_we;
    assign illegal_inst = ctrl_reg.illegal_inst;

endmodule

// File: tb/tb_ama_riscv_ctrl_unit.sv
// Testbench for ama_riscv_ctrl_unit: directed RV32I instruction stream,
// a scheduling-level reference model checked every cycle, plus literal spot checks.

module tb_ama_riscv_ctrl_unit;

    localparam int RST_HOLD       = 2;
    localparam int BR_RES_LAT     = 2;
    localparam int ILLEGAL_BUBBLE = 1;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h40208133;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_ADDI  = 32'h40008093;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_SW    = 32'h0010A023;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_BADLO = 32'h002081B0;

    typedef struct packed {
        logic       stall_if;
        logic       clear_if;
        logic       clear_id;
        logic [1:0] pc_sel;
        logic       pc_we;
        logic       imem_en;
        logic       branch_inst;
        logic       store_inst;
        logic [3:0] alu_op_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] ig_sel;
        logic       bc_uns;
        logic       dmem_en;
        logic       load_sm_en;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       illegal_inst;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_id = 32'h0;
    logic        inst_valid = 1'b0;
    logic        bc_a_eq_b = 1'b0;
    logic        bc_a_lt_b = 1'b0;
    logic        stall_if, clear_if, clear_id, pc_we, imem_en;
    logic        branch_inst, store_inst, alu_a_sel, alu_b_sel, bc_uns;
    logic        dmem_en, load_sm_en, reg_we, illegal_inst;
    logic [1:0]  pc_sel, wb_sel;
    logic [3:0]  alu_op_sel;
    logic [2:0]  ig_sel;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    ama_riscv_ctrl_unit #(
        .RST_HOLD(RST_HOLD), .BR_RES_LAT(BR_RES_LAT), .ILLEGAL_BUBBLE(ILLEGAL_BUBBLE)
    ) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_valid(inst_valid),
        .bc_a_eq_b(bc_a_eq_b), .bc_a_lt_b(bc_a_lt_b),
        .stall_if(stall_if), .clear_if(clear_if), .clear_id(clear_id),
        .pc_sel(pc_sel), .pc_we(pc_we), .imem_en(imem_en),
        .branch_inst(branch_inst), .store_inst(store_inst),
        .alu_op_sel(alu_op_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .ig_sel(ig_sel), .bc_uns(bc_uns), .dmem_en(dmem_en),
        .load_sm_en(load_sm_en), .wb_sel(wb_sel), .reg_we(reg_we),
        .illegal_inst(illegal_inst)
    );

    always #5 clk = ~clk;

    outs_t act;
    assign act = {stall_if, clear_if, clear_id, pc_sel, pc_we, imem_en, branch_inst,
                  store_inst, alu_op_sel, alu_a_sel, alu_b_sel, ig_sel, bc_uns,
                  dmem_en, load_sm_en, wb_sel, reg_we, illegal_inst};

    // ---------------- reference model ----------------
    outs_t exp_o;
    bit    model_on = 0;
    int    hold_left = 0;
    int    sched[$];        // 0 = branch wait, 1 = branch resolve, 2 = jump flush
    logic [2:0] br_f3;

    function automatic outs_t o_reset();
        outs_t o = '0;
        o.pc_sel = 2'd3; o.pc_we = 1; o.imem_en = 1;
        o.stall_if = 1; o.clear_if = 1; o.clear_id = 1;
        return o;
    endfunction

    function automatic outs_t o_nop();
        outs_t o = '0;
        o.pc_we = 1; o.imem_en = 1;
        return o;
    endfunction

    // controls an RV32I instruction needs, by full 7-bit opcode
    function automatic outs_t isa_decode(input logic [31:0] w);
        outs_t o = o_nop();
        logic [2:0] f3 = w[14:12];
        case (w[6:0])
            7'h33: begin o.alu_op_sel = {w[30], f3}; o.wb_sel = 1; o.reg_we = 1; end
            7'h13: begin
                o.alu_op_sel = (f3 == 3'd5) ? {w[30], f3} : {1'b0, f3};
                o.alu_b_sel = 1; o.ig_sel = 1; o.wb_sel = 1; o.reg_we = 1;
            end
            7'h03: begin o.alu_b_sel = 1; o.ig_sel = 1; o.dmem_en = 1; o.load_sm_en = 1;
                         o.wb_sel = 0; o.reg_we = 1; end
            7'h23: begin o.alu_b_sel = 1; o.ig_sel = 2; o.dmem_en = 1; o.store_inst = 1; end
            7'h63: begin o.alu_a_sel = 1; o.alu_b_sel = 1; o.ig_sel = 3; o.branch_inst = 1;
                         o.bc_uns = f3[1]; end
            7'h6F: begin o.alu_a_sel = 1; o.alu_b_sel = 1; o.ig_sel = 4; o.pc_sel = 1;
                         o.wb_sel = 2; o.reg_we = 1; end
            7'h67: begin o.alu_b_sel = 1; o.ig_sel = 1; o.pc_sel = 1; o.wb_sel = 2;
                         o.reg_we = 1; end
            7'h37: begin o.alu_op_sel = 4'hF; o.alu_b_sel = 1; o.ig_sel = 5; o.wb_sel = 1;
                         o.reg_we = 1; end
            7'h17: begin o.alu_a_sel = 1; o.alu_b_sel = 1; o.ig_sel = 5; o.wb_sel = 1;
                         o.reg_we = 1; end
            default: begin o.illegal_inst = 1; o.clear_id = (ILLEGAL_BUBBLE != 0); end
        endcase
        return o;
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int code;
        if (rst) begin
            exp_o = o_reset();
            hold_left = RST_HOLD;
            sched.delete();
            model_on = 1;
        end else if (hold_left > 0) begin
            exp_o = o_reset();
            hold_left--;
        end else if (sched.size() > 0) begin
            code = sched.pop_front();
            exp_o = o_nop();
            if (code == 2) begin
                exp_o.clear_if = 1; exp_o.clear_id = 1;
            end else begin
                exp_o.stall_if = 1; exp_o.clear_id = 1; exp_o.bc_uns = br_f3[1];
                exp_o.pc_we = (code == 1);
                if (code == 1 && branch_taken(br_f3, bc_a_eq_b, bc_a_lt_b)) begin
                    exp_o.pc_sel = 1; exp_o.clear_if = 1;
                end
            end
        end else if (!inst_valid) begin
            exp_o = o_nop();
        end else begin
            exp_o = isa_decode(inst_id);
            if (inst_id[6:0] == 7'h63) begin
                br_f3 = inst_id[14:12];
                for (int k = 0; k < BR_RES_LAT - 1; k++) sched.push_back(0);
                sched.push_back(1);
            end else if (inst_id[6:0] == 7'h6F || inst_id[6:0] == 7'h67) begin
                sched.push_back(2);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // full-output comparison every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            tests++;
            if (act !== exp_o) begin
                fails++;
                $display("FAIL model_cycle_%0d: outputs got %h expected %h", cycle, act, exp_o);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic cyc(input logic [31:0] i, input logic v, input logic e, input logic l);
        inst_id = i; inst_valid = v; bc_a_eq_b = e; bc_a_lt_b = l;
        @(posedge clk);
        #1;
        cycle++;
        $display("[TB] c%0d rst=%b inst=%h v=%b eq=%b lt=%b -> pc_sel=%0d stall=%b clr_if=%b clr_id=%b we=%b ill=%b",
                 cycle, rst, i, v, e, l, pc_sel, stall_if, clear_if, clear_id, reg_we, illegal_inst);
    endtask

    initial begin
        rst = 1;
        repeat (3) cyc(32'h0, 0, 0, 0);
        chk("rst_pc_sel", 32'(pc_sel), 3);
        chk("rst_stall_clear", {stall_if, clear_if, clear_id}, 3'b111);
        chk("rst_wb_sel", 32'(wb_sel), 0);

        rst = 0;
        cyc(I_ADD, 1, 0, 0);
        chk("hold1_pc_sel", 32'(pc_sel), 3);
        chk("hold1_pc_we", 32'(pc_we), 1);
        cyc(I_ADD, 1, 0, 0);
        chk("hold2_pc_sel", 32'(pc_sel), 3);
        cyc(I_ADD, 1, 0, 0);
        chk("add_alu_op", 32'(alu_op_sel), 4'b0000);
        chk("add_wb", 32'(wb_sel), 1);
        chk("add_reg_we", 32'(reg_we), 1);
        chk("add_pc_sel", 32'(pc_sel), 0);

        cyc(I_SUB, 1, 0, 0);
        chk("sub_alu_op", 32'(alu_op_sel), 4'b1000);
        chk("sub_alu_b", 32'(alu_b_sel), 0);
        cyc(I_SRAI, 1, 0, 0);
        chk("srai_alu_op", 32'(alu_op_sel), 4'b1101);
        chk("srai_b_ig", {alu_b_sel, ig_sel}, 4'b1001);
        cyc(I_ADDI, 1, 0, 0);
        chk("addi_f7_ignored", 32'(alu_op_sel), 4'b0000);

        // BEQ taken
        cyc(I_BEQ, 1, 1, 0);
        chk("beq_branch_ig", {branch_inst, ig_sel, reg_we}, 5'b10110);
        cyc(I_ADD, 1, 1, 0);
        chk("beq_wait", {stall_if, pc_we, clear_id, reg_we}, 4'b1010);
        cyc(I_ADD, 1, 1, 0);
        chk("beq_taken", {stall_if, pc_sel, clear_if, pc_we}, 5'b10111);
        cyc(I_ADD, 1, 0, 0);
        chk("after_beq_run", {stall_if, reg_we}, 2'b01);

        // BEQ not taken
        cyc(I_BEQ, 1, 0, 0);
        cyc(I_ADD, 1, 0, 0);
        cyc(I_ADD, 1, 0, 0);
        chk("beq_not_taken", {pc_sel, clear_if, pc_we}, 4'b0001);

        // BLTU taken on lt, BGE not taken on lt, BNE taken on !eq
        cyc(I_BLTU, 1, 0, 1);
        chk("bltu_uns", 32'(bc_uns), 1);
        cyc(I_ADD, 1, 0, 1);
        cyc(I_ADD, 1, 0, 1);
        chk("bltu_taken", 32'(pc_sel), 1);
        cyc(I_BGE, 1, 0, 1);
        cyc(I_ADD, 1, 0, 1);
        cyc(I_ADD, 1, 0, 1);
        chk("bge_not_taken", 32'(pc_sel), 0);
        cyc(I_BNE, 1, 0, 0);
        cyc(I_ADD, 1, 0, 0);
        cyc(I_ADD, 1, 0, 0);
        chk("bne_taken", 32'(clear_if), 1);

        // JAL then flush
        cyc(I_JAL, 1, 0, 0);
        chk("jal_ctrl", {pc_sel, wb_sel, reg_we, ig_sel}, 8'b01_10_1_100);
        cyc(I_ADD, 1, 0, 0);
        chk("jal_flush", {clear_if, clear_id, reg_we}, 3'b110);
        cyc(I_ADD, 1, 0, 0);
        chk("after_jal", {clear_if, reg_we}, 2'b01);

        cyc(I_JALR, 1, 0, 0);
        chk("jalr_a_sel", {alu_a_sel, pc_sel}, 3'b001);
        cyc(I_LW, 1, 0, 0);
        cyc(I_LW, 1, 0, 0);
        chk("lw_ctrl", {dmem_en, load_sm_en, wb_sel, reg_we}, 5'b11001);
        cyc(I_SW, 1, 0, 0);
        chk("sw_ctrl", {store_inst, ig_sel, reg_we}, 5'b10100);
        cyc(I_LUI, 1, 0, 0);
        chk("lui_ctrl", {alu_op_sel, ig_sel}, 7'b1111_101);
        cyc(I_AUIPC, 1, 0, 0);
        chk("auipc_ctrl", {alu_a_sel, alu_op_sel, ig_sel}, 8'b1_0000_101);

        // illegal opcodes
        cyc(I_ILL, 1, 0, 0);
        chk("ill_pulse", {illegal_inst, reg_we, dmem_en, pc_sel, clear_id}, 6'b100001);
        cyc(I_ADD, 1, 0, 0);
        chk("ill_one_cycle", 32'(illegal_inst), 0);
        cyc(I_BADLO, 1, 0, 0);
        chk("ill_low_bits", 32'(illegal_inst), 1);

        // bubble
        cyc(I_SW, 0, 0, 0);
        chk("bubble", {store_inst, dmem_en, pc_we, pc_sel}, 5'b00100);

        // branch followed by jump: jump ignored while resolving
        cyc(I_BEQ, 1, 1, 0);
        cyc(I_JAL, 1, 1, 0);
        cyc(I_JAL, 1, 1, 0);
        chk("br_jmp_resolve", {reg_we, pc_sel}, 3'b001);
        cyc(I_JAL, 1, 0, 0);
        chk("br_jmp_jal", 32'(wb_sel), 2);
        cyc(I_ADD, 1, 0, 0);

        // reset in the middle of a branch wait
        cyc(I_BEQ, 1, 1, 0);
        cyc(I_ADD, 1, 1, 0);
        rst = 1;
        cyc(I_ADD, 1, 1, 0);
        chk("rst_in_br", {pc_sel, stall_if, branch_inst}, 4'b1110);
        rst = 0;
        cyc(I_ADD, 1, 1, 0);
        chk("rst_br_hold1", 32'(pc_sel), 3);
        cyc(I_ADD, 1, 1, 0);
        chk("rst_br_hold2", 32'(pc_sel), 3);
        cyc(I_ADD, 1, 1, 0);
        chk("rst_br_run", {pc_sel, reg_we}, 3'b001);
        cyc(I_SUB, 1, 0, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
